// File: rtl/cpu_pkg.sv
// Shared types for the pipeline hazard / forwarding controller.
package cpu_pkg;

    localparam int MEM_LAT_MAX = 8;
    // Slots store register addresses at this width; narrower designs zero-extend.
    localparam int REG_AW_MAX  = 8;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] rd;
        logic                  wre;
        logic                  is_load;
        logic                  is_mem;
    } stage_slot_t;

endpackage

// File: rtl/hazard_match.sv
// One source-register versus one pipeline-slot producer comparison.
module hazard_match
    import cpu_pkg::*;
#(
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                  i_use,
    input  logic [REG_AW_MAX-1:0] i_src,
    input  logic                  i_valid,
    input  logic                  i_wre,
    input  logic [REG_AW_MAX-1:0] i_rd,
    output logic                  o_hit
);

    // Register 0 is hard-wired when ZERO_REG is set, so it never produces a value.
    assign o_hit = i_use & i_valid & i_wre & (i_rd == i_src) & ((|i_src) | ~ZERO_REG);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline. Keeps a shadow of
// the EX/MEM/WB instructions and derives stall, bubble, flush and bypass selects.
module pipeline_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_AW   = 4,
    parameter int MEM_LAT  = 1,
    parameter bit FWD_EN   = 1'b1,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_wre,
    input  logic              id_is_load,
    input  logic              id_is_store,
    input  logic              id_is_branch,
    input  logic              id_branch_taken,
    output logic              pc_hold,
    output logic              ifid_hold,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              back_hold,
    output logic              memwb_bubble,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    localparam int CNT_W = $clog2(MEM_LAT_MAX);

    // Slot 0 = EX, 1 = MEM, 2 = WB.
    stage_slot_t       r_slot [3];
    logic [REG_AW-1:0] r_ex_rs1;
    logic [REG_AW-1:0] r_ex_rs2;
    logic              r_ex_use1;
    logic              r_ex_use2;
    logic [CNT_W-1:0]  r_mem_cnt;

    // Sources 0/1 are the ID operands, 2/3 the EX operands.
    logic [REG_AW_MAX-1:0] w_src [4];
    logic [3:0]            w_use;
    // w_hit[s][0/1]: ID sources vs EX/MEM, EX sources vs MEM/WB.
    logic [3:0][1:0]       w_hit;
    logic                  w_busy;
    logic                  w_stall;
    logic                  w_id_ex_hit;
    logic                  w_id_mem_hit;
    logic                  w_unused;

    assign w_src[0] = REG_AW_MAX'(id_rs1);
    assign w_src[1] = REG_AW_MAX'(id_rs2);
    assign w_src[2] = REG_AW_MAX'(r_ex_rs1);
    assign w_src[3] = REG_AW_MAX'(r_ex_rs2);
    // EX use bits are cleared for bubbles, so they already imply a valid EX slot.
    assign w_use    = {r_ex_use2, r_ex_use1, id_valid & id_use_rs2, id_valid & id_use_rs1};

    for (genvar s = 0; s < 4; s++) begin : g_src
        for (genvar t = 0; t < 2; t++) begin : g_slot
            hazard_match #(.ZERO_REG(ZERO_REG)) u_match (
                .i_use   (w_use[s]),
                .i_src   (w_src[s]),
                .i_valid (r_slot[s/2 + t].valid),
                .i_wre   (r_slot[s/2 + t].wre),
                .i_rd    (r_slot[s/2 + t].rd),
                .o_hit   (w_hit[s][t])
            );
        end
    end

    assign w_id_ex_hit  = w_hit[0][0] | w_hit[1][0];
    assign w_id_mem_hit = w_hit[0][1] | w_hit[1][1];
    assign w_busy       = (r_mem_cnt != '0);
    // A busy memory freezes everything, so a RAW stall only matters once it clears.
    assign w_stall      = ~w_busy &
                          ((w_id_ex_hit & r_slot[0].is_load) |
                           ((id_is_branch | ~FWD_EN) & (w_id_ex_hit | w_id_mem_hit)));
    assign w_unused     = ^{r_slot[1].is_mem, r_slot[2].is_load, r_slot[2].is_mem};

    function automatic fwd_sel_t fwd_pick(input logic mem_hit, input logic wb_hit,
                                          input logic mem_is_load);
        if (!FWD_EN)                   return FWD_REG;
        if (mem_hit && !mem_is_load)   return FWD_MEM;
        if (wb_hit)                    return FWD_WB;
        return FWD_REG;
    endfunction

    // Control outputs: memory busy outranks data stall outranks normal advance.
    always_comb begin
        pc_hold      = 1'b0;
        ifid_hold    = 1'b0;
        idex_bubble  = 1'b0;
        back_hold    = 1'b0;
        memwb_bubble = 1'b0;
        if (w_busy) begin
            pc_hold      = 1'b1;
            ifid_hold    = 1'b1;
            back_hold    = 1'b1;
            memwb_bubble = 1'b1;
        end else if (w_stall) begin
            pc_hold      = 1'b1;
            ifid_hold    = 1'b1;
            idex_bubble  = 1'b1;
        end
        ifid_flush = ~reset & id_valid & id_is_branch & id_branch_taken & ~w_busy & ~w_stall;
        fwd_a      = fwd_pick(w_hit[2][0], w_hit[2][1], r_slot[1].is_load);
        fwd_b      = fwd_pick(w_hit[3][0], w_hit[3][1], r_slot[1].is_load);
    end

    // Shadow pipeline advance and RAM latency countdown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot[0] <= '0;
            r_slot[1] <= '0;
            r_slot[2] <= '0;
            r_ex_rs1  <= '0;
            r_ex_rs2  <= '0;
            r_ex_use1 <= 1'b0;
            r_ex_use2 <= 1'b0;
            r_mem_cnt <= '0;
        end else if (w_busy) begin
            r_slot[2] <= '0;
            r_mem_cnt <= r_mem_cnt - CNT_W'(1);
        end else begin
            if (r_slot[0].valid && r_slot[0].is_mem)
                r_mem_cnt <= CNT_W'(MEM_LAT - 1);
            r_slot[2] <= r_slot[1];
            r_slot[1] <= r_slot[0];
            if (w_stall || !id_valid) begin
                r_slot[0] <= '0;
                r_ex_rs1  <= '0;
                r_ex_rs2  <= '0;
                r_ex_use1 <= 1'b0;
                r_ex_use2 <= 1'b0;
            end else begin
                r_slot[0] <= '{valid: 1'b1, rd: REG_AW_MAX'(id_rd), wre: id_wre,
                               is_load: id_is_load, is_mem: id_is_load | id_is_store};
                r_ex_rs1  <= id_rs1;
                r_ex_rs2  <= id_rs2;
                r_ex_use1 <= id_use_rs1;
                r_ex_use2 <= id_use_rs2;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: four parameter variants share one ID stream and
// are checked every cycle against an instruction-level model, plus directed cases.
module tb_pipeline_hazard_ctrl;

    typedef struct {
        bit v;
        int rd, rs1, rs2;
        bit u1, u2, wre, ld, st, br, tk;
    } ins_t;

    // Variants: 0 defaults, 1 MEM_LAT=3, 2 MEM_LAT=4 no forwarding, 3 MEM_LAT=2 ZERO_REG=0
    function automatic int lat_of(input int k);
        case (k)
            1: return 3;
            2: return 4;
            3: return 2;
            default: return 1;
        endcase
    endfunction
    function automatic bit fwd_of(input int k); return k != 2; endfunction
    function automatic bit zr_of(input int k);  return k != 3; endfunction

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       id_valid, id_use_rs1, id_use_rs2, id_wre;
    logic       id_is_load, id_is_store, id_is_branch, id_branch_taken;
    logic [3:0] id_rs1, id_rs2, id_rd;
    // {pc_hold, ifid_hold, ifid_flush, idex_bubble, back_hold, memwb_bubble, fwd_a, fwd_b}
    logic [9:0] o [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        logic ph, ih, fl, ib, bh, mb;
        logic [1:0] fa, fb;
        pipeline_hazard_ctrl #(.REG_AW(4), .MEM_LAT(lat_of(g)), .FWD_EN(fwd_of(g)),
                               .ZERO_REG(zr_of(g))) u_dut (
            .clk(clk), .reset(reset), .id_valid(id_valid),
            .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
            .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_wre(id_wre),
            .id_is_load(id_is_load), .id_is_store(id_is_store),
            .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken),
            .pc_hold(ph), .ifid_hold(ih), .ifid_flush(fl), .idex_bubble(ib),
            .back_hold(bh), .memwb_bubble(mb), .fwd_a(fa), .fwd_b(fb));
        assign o[g] = {ph, ih, fl, ib, bh, mb, fa, fb};
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // ---------------- instruction constructors ----------------
    function automatic ins_t nop();
        ins_t x = '{default: 0};
        return x;
    endfunction
    function automatic ins_t alu(input int rd, input int a, input int b);
        ins_t x = '{default: 0};
        x.v = 1; x.rd = rd; x.rs1 = a; x.rs2 = b; x.u1 = 1; x.u2 = 1; x.wre = 1;
        return x;
    endfunction
    function automatic ins_t ld(input int rd, input int a);
        ins_t x = '{default: 0};
        x.v = 1; x.rd = rd; x.rs1 = a; x.u1 = 1; x.wre = 1; x.ld = 1;
        return x;
    endfunction
    function automatic ins_t st(input int a, input int b);
        ins_t x = '{default: 0};
        x.v = 1; x.rs1 = a; x.rs2 = b; x.u1 = 1; x.u2 = 1; x.st = 1;
        return x;
    endfunction
    function automatic ins_t br(input int a, input int b, input bit tk);
        ins_t x = '{default: 0};
        x.v = 1; x.rs1 = a; x.rs2 = b; x.u1 = 1; x.u2 = 1; x.br = 1; x.tk = tk;
        return x;
    endfunction
    function automatic ins_t rnd();
        int   kind = $urandom_range(0, 4);
        int   a = $urandom_range(0, 3);
        int   b = $urandom_range(0, 3);
        int   d = $urandom_range(0, 3);
        ins_t x;
        case (kind)
            0, 1:    x = alu(d, a, b);
            2:       x = ld(d, a);
            3:       x = st(a, b);
            default: x = br(a, b, 1'($urandom_range(0, 1)));
        endcase
        if (kind < 2) x.u2 = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) > 7) x.v = 0;
        return x;
    endfunction

    // ---------------- reference model ----------------
    // In-flight instructions per variant: [0] in EX, [1] in MEM, [2] in WB.
    ins_t mp [4][3];
    int   mcnt [4];
    ins_t cur;

    // Does instruction p produce register src for a consumer that reads it?
    function automatic bit hits(input bit u, input int src, input ins_t p, input int k);
        return u && p.v && p.wre && (p.rd == src) && !(src == 0 && zr_of(k));
    endfunction

    function automatic logic [1:0] fsel(input int k, input bit u, input int src);
        if (hits(u, src, mp[k][1], k) && !mp[k][1].ld) return 2'd2;
        if (hits(u, src, mp[k][2], k)) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [9:0] mexp(input int k, input ins_t id);
        bit busy  = (mcnt[k] != 0);
        bit pex   = id.v && (hits(id.u1, id.rs1, mp[k][0], k) || hits(id.u2, id.rs2, mp[k][0], k));
        bit pmem  = id.v && (hits(id.u1, id.rs1, mp[k][1], k) || hits(id.u2, id.rs2, mp[k][1], k));
        bit stall = !busy && ((pex && mp[k][0].ld) || ((id.br || !fwd_of(k)) && (pex || pmem)));
        bit flush = id.v && id.br && id.tk && !busy && !stall;
        logic [1:0] fa = (fwd_of(k) && mp[k][0].v) ? fsel(k, mp[k][0].u1, mp[k][0].rs1) : 2'd0;
        logic [1:0] fb = (fwd_of(k) && mp[k][0].v) ? fsel(k, mp[k][0].u2, mp[k][0].rs2) : 2'd0;
        return {busy | stall, busy | stall, flush, stall, busy, busy, fa, fb};
    endfunction

    task automatic mstep(input int k, input ins_t id);
        logic [9:0] e = mexp(k, id);
        if (mcnt[k] != 0) begin
            mp[k][2] = nop();
            mcnt[k]--;
        end else begin
            if (mp[k][0].v && (mp[k][0].ld || mp[k][0].st)) mcnt[k] = lat_of(k) - 1;
            mp[k][2] = mp[k][1];
            mp[k][1] = mp[k][0];
            mp[k][0] = (e[6] || !id.v) ? nop() : id;
        end
    endtask

    task automatic mreset();
        for (int k = 0; k < 4; k++) begin
            mcnt[k] = 0;
            for (int j = 0; j < 3; j++) mp[k][j] = nop();
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input ins_t i);
        cur             = i;
        id_valid        = i.v;
        id_rs1          = 4'(i.rs1);
        id_rs2          = 4'(i.rs2);
        id_rd           = 4'(i.rd);
        id_use_rs1      = i.u1;
        id_use_rs2      = i.u2;
        id_wre          = i.wre;
        id_is_load      = i.ld;
        id_is_store     = i.st;
        id_is_branch    = i.br;
        id_branch_taken = i.tk;
    endtask

    // Present an ID instruction and compare every variant with the model.
    task automatic put(input ins_t i);
        drive(i);
        #1;
        for (int k = 0; k < 4; k++) chk($sformatf("model_v%0d", k), o[k], mexp(k, cur));
    endtask

    task automatic adv();
        @(posedge clk);
        for (int k = 0; k < 4; k++) mstep(k, cur);
        @(negedge clk);
    endtask

    // Hold an instruction in ID until variant tgt accepts it; returns stall cycles.
    task automatic issue(input ins_t i, input int tgt, output int stalls, output logic [9:0] first);
        put(i);
        first  = o[tgt];
        stalls = 0;
        while (o[tgt][9] && stalls < 20) begin
            adv();
            put(i);
            stalls++;
        end
        n_tests++;
        assert (stalls < 20) else begin
            n_fail++;
            $error("FAIL issue_bound: variant %0d stalled %0d cycles, limit 20", tgt, stalls);
        end
    endtask

    task automatic drain();
        repeat (8) begin put(nop()); adv(); end
    endtask

    task automatic rst_chk(input string tag);
        for (int k = 0; k < 4; k++) chk($sformatf("%s_v%0d", tag, k), o[k], 10'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         s;
        logic [9:0] f;
        mreset();
        // Taken branch in ID while reset is high must not flush.
        drive(br(1, 2, 1'b1));
        #12;
        rst_chk("reset_hold");
        @(negedge clk);
        reset = 1'b0;
        put(nop());
        rst_chk("post_reset");
        adv();

        // ADD r3 ; SUB r4=r3-r1 ; OR r5=r3|r0
        issue(alu(3, 1, 2), 0, s, f); adv();
        issue(alu(4, 3, 1), 0, s, f);
        chk("addsub_nostall", 10'(s), 10'd0); adv();
        issue(alu(5, 3, 0), 0, s, f);
        chk("fwd_mem", 10'(o[0][3:2]), 10'd2);
        chk("fwd_mem_nohold", 10'(o[0][9]), 10'd0); adv();
        issue(nop(), 0, s, f);
        chk("fwd_wb", 10'(o[0][3:2]), 10'd1); adv();

        // LOAD r5 ; ADD r6=r5+r2
        drain();
        issue(ld(5, 1), 0, s, f); adv();
        issue(alu(6, 5, 2), 0, s, f);
        chk("ldu_stalls", 10'(s), 10'd1);
        chk("ldu_ctl", 10'({f[9], f[8], f[6]}), 10'd7); adv();
        issue(nop(), 0, s, f);
        chk("ldu_fwd_wb", 10'(o[0][3:2]), 10'd1); adv();

        // MEM_LAT=3: STORE then three ALU ops chained through r7
        drain();
        issue(st(1, 2), 1, s, f); adv();
        issue(alu(7, 1, 2), 1, s, f);
        chk("st_first_nostall", 10'(s), 10'd0); adv();
        issue(alu(8, 7, 0), 1, s, f);
        chk("st_hold_cycles", 10'(s), 10'd2);
        chk("st_hold_ctl", 10'({f[5], f[4], f[6]}), 10'd6); adv();
        issue(alu(9, 0, 7), 1, s, f);
        chk("st_fwd_mem", 10'(o[1][3:2]), 10'd2); adv();
        issue(nop(), 1, s, f);
        chk("st_fwd_wb", 10'(o[1][1:0]), 10'd1); adv();

        // BEQ r2 right after ADD r2, then a hazard-free taken branch
        drain();
        issue(alu(2, 1, 1), 0, s, f); adv();
        issue(br(2, 3, 1'b1), 0, s, f);
        chk("br_raw_stalls", 10'(s), 10'd2);
        chk("br_stall_ctl", 10'({f[9], f[7], f[6]}), 10'd5);
        chk("br_raw_flush", 10'(o[0][7]), 10'd1); adv();
        issue(br(4, 5, 1'b1), 0, s, f);
        chk("br_free_stalls", 10'(s), 10'd0);
        chk("br_free_flush", 10'(o[0][7]), 10'd1); adv();
        issue(nop(), 0, s, f);
        chk("br_flush_clear", 10'(o[0][7]), 10'd0); adv();

        // FWD_EN=0: ADD r1 ; SUB reading r1, then r0 producer
        drain();
        issue(alu(1, 2, 3), 2, s, f); adv();
        issue(alu(4, 1, 2), 2, s, f);
        chk("nofwd_stalls", 10'(s), 10'd2); adv();
        issue(nop(), 2, s, f);
        chk("nofwd_sel", 10'(o[2][3:0]), 10'd0); adv();
        issue(alu(0, 1, 1), 2, s, f); adv();
        issue(alu(5, 0, 0), 2, s, f);
        chk("zr_nostall", 10'(s), 10'd0); adv();
        put(nop());
        chk("zr_on_nofwd", 10'(o[0][3:0]), 10'd0);
        chk("zr_off_fwd", 10'(o[3][3:2]), 10'd2); adv();

        // Reset in the middle of a MEM_LAT=4 countdown
        drain();
        issue(ld(1, 2), 2, s, f); adv();
        put(nop()); adv();
        put(nop());
        chk("cnt_busy", 10'(o[2][5]), 10'd1);
        #2 reset = 1'b1;
        #1 rst_chk("mid_reset");
        mreset();
        @(negedge clk);
        reset = 1'b0;
        put(nop());
        rst_chk("post_reset2");
        adv();
        issue(ld(1, 2), 2, s, f); adv();
        issue(nop(), 2, s, f); adv();
        issue(alu(3, 4, 4), 2, s, f);
        chk("lat4_hold_cycles", 10'(s), 10'd3); adv();

        // Random ID stream against the model
        drain();
        repeat (400) begin
            put(rnd());
            adv();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised hazard and forwarding controller for the 5-stage pipelined CPU (IF, ID, EX, MEM, WB). It keeps its own shadow of the instructions in EX, MEM and WB. From that shadow it produces:
- stall, bubble and flush controls for the PC and the stage registers;
- 3-input forwarding selects for the ALU operand muxes.

It adds multi-cycle RAM latency, branch-in-decode RAW stalls and a no-forwarding mode. It replaces the combinational hazard_detection_unit and the hand-driven forwarding selects.

## Interface
Parameters:
- REG_AW, 4: register-address width.
- MEM_LAT, 1: RAM access cycles per load/store, range 1..8.
- FWD_EN, 1: 1 = forward from MEM/WB; 0 = stall on RAW until the producer reaches WB.
- ZERO_REG, 1: 1 = register 0 is never a hazard or forwarding source.

Ports:
- clk  in  1  pipeline clock. One clock; reset is asynchronous and active-high.
- reset  in  1  asynchronous, active-high; clears all state.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2, id_rd  in  REG_AW  ID source and destination fields.
- id_use_rs1, id_use_rs2  in  1  the instruction reads that source.
- id_wre  in  1  the instruction writes the regfile.
- id_is_load, id_is_store  in  1  memory access type.
- id_is_branch  in  1  branch compared in decode.
- id_branch_taken  in  1  comparator result.
- pc_hold  out  1  hold PC.
- ifid_hold  out  1  hold the FetchDecode register.
- ifid_flush  out  1  load NOP into FetchDecode.
- idex_bubble  out  1  zero the control word into DecodeExecute (drives the NOP mux).
- back_hold  out  1  hold DecodeExecute and ExecuteMemory.
- memwb_bubble  out  1  load an invalid/zero-write entry into MemoryWriteback.
- fwd_a, fwd_b  out  2  0 = register value, 1 = writeback_data, 2 = alu_result_memory. Value 3 is never driven.

## Operation
- Shadow slots EX, MEM and WB each hold {valid, rd, wre, is_load, is_mem}. EX also holds rs1/rs2 and their use bits.
- A source matches a slot when all of these hold:
  - the use bit is set;
  - the slot is valid with wre set;
  - rd equals the source;
  - rd is not 0, or ZERO_REG is 0.
- Priority per cycle (highest first):
  1. mem_busy, meaning mem_cnt is not 0. Result: pc_hold = ifid_hold = back_hold = memwb_bubble = 1. EX and MEM hold; WB becomes invalid; mem_cnt decrements.
  2. data_stall. Result: pc_hold = ifid_hold = idex_bubble = 1. EX becomes a bubble; MEM takes EX; WB takes MEM. data_stall is set by any of:
     - load-use: a source in ID matches EX with is_load set;
     - branch RAW: id_is_branch and a source matches EX or MEM;
     - FWD_EN = 0: a source matches EX or MEM.
  3. Normal advance. ID moves to EX, EX to MEM, MEM to WB. An invalid ID enters EX as a bubble.
- ifid_flush = id_valid & id_is_branch & id_branch_taken & no stall. A stalled branch is re-evaluated next cycle.
- mem_cnt is loaded with MEM_LAT−1 when an is_mem instruction advances into MEM. It is never loaded while already nonzero.
- Forwarding applies to the EX slot, using use bits, for fwd_a (rs1) and fwd_b (rs2):
  - If the source matches MEM and MEM is not a load: select 2.
  - Otherwise, if it matches WB: select 1.
  - Otherwise: select 0.
  - MEM takes precedence over WB.
  - With FWD_EN = 0, both selects are always 0.
- The regfile is write-first. A producer in WB never causes a stall.

## Timing
- All outputs are combinational from the slots, mem_cnt and the ID inputs. No internal output latency.
- Slots update on posedge clk.
- Reset (asynchronous, any time, including mid-stall or mid-count):
  - all slots become invalid and mem_cnt becomes 0;
  - every output is 0 while reset is high and on the first cycle after reset;
  - operation resumes on the first posedge after reset falls.
- Load-use costs exactly 1 bubble. The dependent instruction then sees fwd = 1 from WB.
- A load or store with MEM_LAT = N holds the back end for N−1 cycles.
- Branch RAW costs 1 or 2 cycles, depending on whether the producer is in MEM or in EX.

## Structure
- Package cpu_pkg holds:
  - typedef fwd_sel_t, 2 bits: FWD_REG = 0, FWD_WB = 1, FWD_MEM = 2;
  - slot struct typedef stage_slot_t;
  - constant MEM_LAT_MAX = 8.
- Sub-module hazard_match: combinational source/slot comparison, with the ZERO_REG rule. Instanced per source × slot.

## Test plan
- ADD r3 followed by SUB reading r3, defaults. In the SUB's EX cycle: fwd_a = 2 and no stall. One cycle later, a third instruction reading r3 gets fwd = 1.
- LOAD r5 followed by ADD reading r5. One cycle with pc_hold = ifid_hold = idex_bubble = 1, then fwd = 1 for the ADD in EX.
- MEM_LAT = 3, STORE followed by 3 ALU ops. back_hold = memwb_bubble = 1 for exactly 2 cycles. No instruction is lost or duplicated.
- BEQ r2 directly after ADD r2. 2 stall cycles, then ifid_flush = 1 if taken. A taken branch with no hazard gives a 1-cycle flush and no stall.
- FWD_EN = 0, ADD r1 followed by SUB reading r1. 2 stall cycles, fwd stays 0. With ZERO_REG = 1, a producer writing r0 causes no stall.
- Assert reset during the MEM_LAT = 4 countdown. All outputs go to 0 immediately. The first post-reset LOAD triggers a fresh 3-cycle hold.
